char_health_ctrl: RTL and testbench

- Owns the player's hit points.
- Detects character/boss contact, accepts external hit requests (projectiles), applies damage with a frame-based invulnerability window, and declares death.
- Sits directly upstream of the character draw block: its char_hp output drives that block's char_hp input, which feeds the heart display.
- Game-state logic uses char_dead to end the round.

---
 rtl/char_health_if.sv | 26 ++
 rtl/char_health_ctrl.sv | 105 ++++++++++
 tb/tb_char_health_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/char_health_if.sv
// char_health_if: game-side bus of the character health controller
interface char_health_if;
    logic        frame_tick;
    logic [1:0]  game_active;
    logic        game_start;
    logic [11:0] char_x, char_y, char_lng, char_hgt;
    logic [11:0] boss_x, boss_y, boss_lng, boss_hgt;
    logic        hit_req;
    logic [3:0]  hit_dmg;
    logic [3:0]  char_hp;
    logic        invuln, hit_pulse, char_dead;
    modport master(
        output frame_tick, game_active, game_start,
        output char_x, char_y, char_lng, char_hgt,
        output boss_x, boss_y, boss_lng, boss_hgt,
        output hit_req, hit_dmg,
        input  char_hp, invuln, hit_pulse, char_dead
    );
    modport slave(
        input  frame_tick, game_active, game_start,
        input  char_x, char_y, char_lng, char_hgt,
        input  boss_x, boss_y, boss_lng, boss_hgt,
        input  hit_req, hit_dmg,
        output char_hp, invuln, hit_pulse, char_dead
    );
endinterface

// File: rtl/char_health_ctrl.sv
// char_health_ctrl: player HP, boss contact / hit damage, invulnerability window and death.
// Optional CHAR_HP_REGEN_EN adds slow HP regeneration while alive.
module char_health_ctrl #(
    parameter int MAX_HP        = 5,
    parameter int INVULN_FRAMES = 60,
    parameter int CONTACT_DMG   = 1,
    parameter int REGEN_FRAMES  = 300
) (
    input logic         clk,
    input logic         rst,
    char_health_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ALIVE  = 2'd1;
    localparam logic [1:0] S_INVULN = 2'd2;
    localparam logic [1:0] S_DEAD   = 2'd3;
    localparam logic [3:0] HP_MAX   = 4'(MAX_HP);
    localparam logic [3:0] C_DMG    = 4'(CONTACT_DMG);
    localparam logic [7:0] INV_LOAD = 8'(INVULN_FRAMES);

    if (MAX_HP < 1 || MAX_HP > 15 || INVULN_FRAMES < 1 || INVULN_FRAMES > 255 ||
        CONTACT_DMG < 0 || CONTACT_DMG > 15 || REGEN_FRAMES < 1) begin : g_bad_param
        $error("char_health_ctrl: parameter out of range");
    end

    logic [1:0]         state;
    logic [3:0]         hp;
    logic [7:0]         inv_cnt;
    logic               ov_q, ov_prev, pulse;
    logic signed [12:0] dx, dy;
    logic [12:0]        adx, ady, sx, sy;
    logic               ov_d, contact, active, take, inv_tick, regen_step;
    logic [3:0]         dmg, hp_sub;

    always_comb begin
        dx  = {1'b0, bus.char_x} - {1'b0, bus.boss_x};
        dy  = {1'b0, bus.char_y} - {1'b0, bus.boss_y};
        adx = dx[12] ? 13'(-dx) : 13'(dx);
        ady = dy[12] ? 13'(-dy) : 13'(dy);
        sx  = {1'b0, bus.char_lng} + {1'b0, bus.boss_lng};
        sy  = {1'b0, bus.char_hgt} + {1'b0, bus.boss_hgt};
        ov_d = (adx < sx) && (ady < sy);
    end

    // simultaneous contact and projectile take the larger hit, never the sum
    assign contact  = ov_q & ~ov_prev;
    assign dmg      = (contact && bus.hit_req) ? ((bus.hit_dmg > C_DMG) ? bus.hit_dmg : C_DMG) :
                      contact ? C_DMG : bus.hit_req ? bus.hit_dmg : 4'd0;
    assign active   = bus.game_active == 2'd1;
    assign take     = state == S_ALIVE && active && dmg != 4'd0 && !bus.game_start;
    assign hp_sub   = (hp > dmg) ? hp - dmg : 4'd0;
    assign inv_tick = state == S_INVULN && active && bus.frame_tick && !bus.game_start;

`ifdef CHAR_HP_REGEN_EN
    localparam int RW = $clog2(REGEN_FRAMES + 1);
    logic [RW-1:0] regen_cnt;
    logic          regen_tick;

    assign regen_tick = state == S_ALIVE && active && hp < HP_MAX && bus.frame_tick;
    assign regen_step = regen_tick && !take && !bus.game_start && regen_cnt == RW'(REGEN_FRAMES - 1);

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            regen_cnt <= '0;
        else if (bus.game_start || take || state != S_ALIVE || hp >= HP_MAX || regen_step)
            regen_cnt <= '0;
        else if (regen_tick)
            regen_cnt <= regen_cnt + RW'(1);
`else
    assign regen_step = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state   <= S_IDLE;
            hp      <= HP_MAX;
            inv_cnt <= 8'd0;
            ov_q    <= 1'b0;
            ov_prev <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            ov_q    <= ov_d;
            ov_prev <= ov_q;
            pulse   <= take;
            if (bus.game_start) begin
                state   <= S_ALIVE;
                hp      <= HP_MAX;
                inv_cnt <= 8'd0;
            end else if (take) begin
                hp      <= hp_sub;
                state   <= (hp_sub == 4'd0) ? S_DEAD : S_INVULN;
                inv_cnt <= (hp_sub == 4'd0) ? 8'd0 : INV_LOAD;
            end else if (inv_tick) begin
                inv_cnt <= inv_cnt - 8'd1;
                state   <= (inv_cnt == 8'd1) ? S_ALIVE : S_INVULN;
            end else if (regen_step) begin
                hp <= hp + 4'd1;
            end
        end

    assign bus.char_hp   = hp;
    assign bus.invuln    = state == S_INVULN;
    assign bus.hit_pulse = pulse;
    assign bus.char_dead = state == S_DEAD;
endmodule

// File: tb/tb_char_health_ctrl.sv
// tb_char_health_ctrl: directed scenarios plus random play checked against a frame-level model
module tb_char_health_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    char_health_if bus();

    char_health_ctrl dut(.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_ALIVE, M_INV, M_DEAD} mst_t;
    mst_t m_st = M_IDLE;
    int   m_hp = 5, m_left = 0;
    bit   m_pulse = 0, m_ov = 0, m_ovp = 0;
    int   n_vec = 0, n_bad = 0, pulses = 0, inv_ticks = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit overlap_now();
        int dx = int'(bus.char_x) - int'(bus.boss_x);
        int dy = int'(bus.char_y) - int'(bus.boss_y);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return dx < int'(bus.char_lng) + int'(bus.boss_lng) && dy < int'(bus.char_hgt) + int'(bus.boss_hgt);
    endfunction

    task automatic model_step();
        bit contact = m_ov && !m_ovp;
        bit act = bus.game_active == 2'd1;
        int dmg = 0;
        if (contact) dmg = 1;
        if (bus.hit_req && int'(bus.hit_dmg) > dmg) dmg = int'(bus.hit_dmg);
        m_pulse = 0;
        if (bus.game_start) begin
            m_st = M_ALIVE; m_hp = 5; m_left = 0;
        end else if (m_st == M_ALIVE && act && dmg > 0) begin
            m_hp = (m_hp > dmg) ? m_hp - dmg : 0;
            m_pulse = 1;
            if (m_hp == 0) m_st = M_DEAD;
            else begin m_st = M_INV; m_left = 60; end
        end else if (m_st == M_INV && act && bus.frame_tick) begin
            m_left--;
            if (m_left == 0) m_st = M_ALIVE;
        end
        m_ovp = m_ov;
        m_ov  = overlap_now();
    endtask

    task automatic cyc();
        if (bus.invuln && bus.frame_tick && bus.game_active == 2'd1) inv_ticks++;
        model_step();
        @(posedge clk);
        #1;
        chk("hp", 32'(bus.char_hp), 32'(m_hp));
        chk("invuln", 32'(bus.invuln), 32'(m_st == M_INV));
        chk("hit_pulse", 32'(bus.hit_pulse), 32'(m_pulse));
        chk("char_dead", 32'(bus.char_dead), 32'(m_st == M_DEAD));
        if (bus.hit_pulse) pulses++;
    endtask

    task automatic place(int cx, int cy, int cl, int ch, int bx, int by, int bl, int bh);
        bus.char_x = 12'(cx); bus.char_y = 12'(cy); bus.char_lng = 12'(cl); bus.char_hgt = 12'(ch);
        bus.boss_x = 12'(bx); bus.boss_y = 12'(by); bus.boss_lng = 12'(bl); bus.boss_hgt = 12'(bh);
    endtask

    task automatic hit(int d);
        bus.hit_req = 1'b1; bus.hit_dmg = 4'(d);
        cyc();
        bus.hit_req = 1'b0; bus.hit_dmg = 4'd0;
    endtask

    task automatic start();
        bus.game_start = 1'b1;
        cyc();
        bus.game_start = 1'b0;
    endtask

    initial begin
        bus.frame_tick = 0; bus.game_active = 2'd0; bus.game_start = 0;
        bus.hit_req = 0; bus.hit_dmg = 0;
        place(100, 100, 16, 16, 1000, 1000, 32, 32);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hp", 32'(bus.char_hp), 32'd5);
        chk("rst_invuln", 32'(bus.invuln), 32'd0);
        chk("rst_pulse", 32'(bus.hit_pulse), 32'd0);
        chk("rst_dead", 32'(bus.char_dead), 32'd0);
        rst = 1'b1;
        hit(3);
        chk("idle_ignores_hit", 32'(bus.char_hp), 32'd5);

        bus.game_active = 2'd1;
        start();
        chk("start_hp", 32'(bus.char_hp), 32'd5);
        chk("start_dead", 32'(bus.char_dead), 32'd0);

        repeat (3) cyc();
        pulses = 0; inv_ticks = 0;
        place(100, 100, 16, 16, 120, 100, 32, 32);
        for (int i = 0; i < 400; i++) begin
            bus.frame_tick = i[0];
            cyc();
        end
        bus.frame_tick = 0;
        chk("held_contact_pulses", 32'(pulses), 32'd1);
        chk("held_contact_hp", 32'(bus.char_hp), 32'd4);
        chk("held_contact_inv_ticks", 32'(inv_ticks), 32'd60);
        chk("held_contact_inv_end", 32'(bus.invuln), 32'd0);

        start();
        place(100, 100, 16, 16, 1000, 100, 32, 32);
        repeat (3) cyc();
        pulses = 0;
        place(100, 100, 16, 16, 120, 100, 32, 32);
        cyc();
        hit(2);
        chk("max_rule_hp", 32'(bus.char_hp), 32'd3);
        cyc();
        chk("max_rule_pulses", 32'(pulses), 32'd1);

        place(100, 100, 16, 16, 1000, 100, 32, 32);
        bus.frame_tick = 1;
        repeat (70) cyc();
        bus.frame_tick = 0;
        chk("inv_over", 32'(bus.invuln), 32'd0);
        hit(9);
        chk("kill_hp", 32'(bus.char_hp), 32'd0);
        chk("kill_dead", 32'(bus.char_dead), 32'd1);
        cyc();
        hit(3);
        cyc();
        chk("dead_ignores_hp", 32'(bus.char_hp), 32'd0);
        chk("dead_ignores_pulse", 32'(bus.hit_pulse), 32'd0);
        start();
        chk("restart_hp", 32'(bus.char_hp), 32'd5);
        chk("restart_dead", 32'(bus.char_dead), 32'd0);

        pulses = 0;
        place(100, 100, 16, 16, 148, 100, 32, 32);
        repeat (6) cyc();
        place(100, 100, 16, 16, 1000, 100, 32, 32);
        repeat (3) cyc();
        place(100, 100, 16, 16, 100, 52, 32, 32);
        repeat (6) cyc();
        chk("edge_touch_pulses", 32'(pulses), 32'd0);
        chk("edge_touch_hp", 32'(bus.char_hp), 32'd5);
        place(100, 100, 16, 16, 1000, 100, 32, 32);
        repeat (3) cyc();
        inv_ticks = 0;
        place(100, 100, 16, 16, 147, 100, 32, 32);
        repeat (4) cyc();
        chk("just_inside_pulses", 32'(pulses), 32'd1);
        chk("just_inside_hp", 32'(bus.char_hp), 32'd4);

        place(100, 100, 16, 16, 1000, 100, 32, 32);
        bus.frame_tick = 1;
        repeat (10) cyc();
        bus.game_active = 2'd2;
        repeat (30) cyc();
        chk("frozen_invuln", 32'(bus.invuln), 32'd1);
        bus.game_active = 2'd1;
        for (int i = 0; i < 100 && bus.invuln; i++) cyc();
        bus.frame_tick = 0;
        chk("freeze_inv_ticks", 32'(inv_ticks), 32'd60);
        chk("freeze_inv_end", 32'(bus.invuln), 32'd0);

        pulses = 0;
        bus.game_active = 2'd0;
        place(100, 100, 16, 16, 120, 100, 32, 32);
        repeat (5) cyc();
        bus.game_active = 2'd1;
        repeat (5) cyc();
        chk("resume_no_spurious", 32'(pulses), 32'd0);

        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(29) == 0) begin
                int cx = int'($urandom_range(3900, 100));
                int cy = int'($urandom_range(3900, 100));
                int cl = int'($urandom_range(40, 1));
                int ch = int'($urandom_range(40, 1));
                int bl = int'($urandom_range(40, 1));
                int bh = int'($urandom_range(40, 1));
                int bx = cx + int'($urandom_range(200)) - 100;
                int by = cy + int'($urandom_range(200)) - 100;
                if ($urandom_range(3) == 0) bx = cx + cl + bl - int'($urandom_range(1));
                place(cx, cy, cl, ch, bx, by, bl, bh);
            end
            if ($urandom_range(199) == 0)
                bus.game_active = ($urandom_range(1) == 0) ? 2'd1 : 2'($urandom_range(3));
            bus.frame_tick = $urandom_range(2) == 0;
            bus.game_start = $urandom_range(499) == 0;
            bus.hit_req = $urandom_range(24) == 0;
            bus.hit_dmg = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(2));
            cyc();
        end
        bus.frame_tick = 0; bus.game_start = 0; bus.hit_req = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
